// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS controller.
// Holds the FSM state encoding, the opcode/funct constants, the datapath
// op-select codes and the decoded-instruction record that the decoder hands
// to the controller FSM.
package mips_pkg;

   // FSM states, also exported on state_o for debug.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // Next-pc select
   typedef logic [2:0] npc_op_t;
   localparam npc_op_t NPC_PC4  = 3'd0;
   localparam npc_op_t NPC_BEQ  = 3'd1;
   localparam npc_op_t NPC_JUMP = 3'd2;
   localparam npc_op_t NPC_RS   = 3'd3;

   // Register read port 1 address select
   localparam logic A1_RS = 1'b0;
   localparam logic A1_RT = 1'b1;

   // Register write address select
   typedef logic [1:0] reg_addr_op_t;
   localparam reg_addr_op_t RA_RD  = 2'd0;
   localparam reg_addr_op_t RA_RT  = 2'd1;
   localparam reg_addr_op_t RA_R31 = 2'd2;

   // Register write data select
   typedef logic [2:0] reg_data_op_t;
   localparam reg_data_op_t RD_ALU = 3'd0;
   localparam reg_data_op_t RD_DM  = 3'd1;
   localparam reg_data_op_t RD_LUI = 3'd2;
   localparam reg_data_op_t RD_PC4 = 3'd3;
   localparam reg_data_op_t RD_LH  = 3'd4;
   localparam reg_data_op_t RD_SLT = 3'd5;

   // ALU operation
   typedef logic [3:0] alu_op_t;
   localparam alu_op_t ALU_ADD = 4'd0;
   localparam alu_op_t ALU_SUB = 4'd1;
   localparam alu_op_t ALU_OR  = 4'd2;
   localparam alu_op_t ALU_SLL = 4'd3;

   // ALU operand B select
   typedef logic [2:0] alu_b_op_t;
   localparam alu_b_op_t B_RT    = 3'd0;
   localparam alu_b_op_t B_SIMM  = 3'd1;
   localparam alu_b_op_t B_ZIMM  = 3'd2;
   localparam alu_b_op_t B_SHAMT = 3'd3;

   // Instruction class: which state sequence the instruction walks.
   //   SEQ_ALU     F-D-E-W      SEQ_LOAD   F-D-E-M-W
   //   SEQ_STORE   F-D-E-M      SEQ_BRANCH F-D-E (beq, jr)
   //   SEQ_JAL     F-D-W        SEQ_ILLEGAL F-D
   typedef enum logic [2:0] {
      SEQ_ALU     = 3'd0,
      SEQ_LOAD    = 3'd1,
      SEQ_STORE   = 3'd2,
      SEQ_BRANCH  = 3'd3,
      SEQ_JAL     = 3'd4,
      SEQ_ILLEGAL = 3'd5
   } seq_t;

   // Decoded instruction: class plus every select field the datapath needs.
   typedef struct packed {
      seq_t         seq;
      alu_op_t      alu_op;
      alu_b_op_t    alu_b_op;
      logic         a1_op;
      reg_addr_op_t reg_addr_op;
      reg_data_op_t reg_data_op;
      npc_op_t      next_pc_op;
   } dec_t;

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath bundle.
// Signals:
//   instr        instruction word for the current pc (datapath -> controller)
//   ir_en        instruction register load strobe
//   pc_en        pc update strobe, once per instruction, in its final state
//   next_pc_op   next-pc select, valid only while pc_en is high
//   reg_write    register-file write strobe (WB only)
//   a1_op        register read port 1 address select
//   reg_addr_op  register write address select
//   reg_data_op  register write data select
//   alu_op       ALU operation
//   alu_b_op     ALU operand B select
//   mem_write    data-memory write strobe (MEM of sw only)
// Strobe semantics: every strobe is a single-cycle, level-sampled pulse; the
// datapath acts on the rising edge that ends the cycle in which it is high.
// There is no back-pressure: the datapath always accepts a strobe.
// Modports: master = controller, slave = datapath.
interface mc_controller_if;
   import mips_pkg::*;

   logic [31:0]  instr;
   logic         ir_en;
   logic         pc_en;
   npc_op_t      next_pc_op;
   logic         reg_write;
   logic         a1_op;
   reg_addr_op_t reg_addr_op;
   reg_data_op_t reg_data_op;
   alu_op_t      alu_op;
   alu_b_op_t    alu_b_op;
   logic         mem_write;

   modport master (
      input  instr,
      output ir_en, pc_en, next_pc_op, reg_write, a1_op, reg_addr_op,
             reg_data_op, alu_op, alu_b_op, mem_write
   );

   modport slave (
      output instr,
      input  ir_en, pc_en, next_pc_op, reg_write, a1_op, reg_addr_op,
             reg_data_op, alu_op, alu_b_op, mem_write
   );
endinterface

// File: rtl/mc_decoder.sv
// mc_decoder: purely combinational instruction decoder.
// Ports:
//   ir   in   instruction register contents
//   dec  out  instruction class and all datapath select fields
// Anything not listed in the supported set decodes to SEQ_ILLEGAL with all
// select fields zero, so an illegal instruction never drives a write.
module mc_decoder
   import mips_pkg::*;
(
   input  logic [31:0] ir,
   output dec_t        dec
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_fields;

   assign opcode = ir[31:26];
   assign funct  = ir[5:0];
   // Register and immediate fields are consumed by the datapath, not here.
   assign unused_fields = ^ir[25:6];

   always_comb begin
      dec     = '0;
      dec.seq = SEQ_ILLEGAL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: begin
                  dec.seq         = SEQ_ALU;
                  dec.alu_op      = ALU_ADD;
                  dec.alu_b_op    = B_RT;
                  dec.reg_addr_op = RA_RD;
                  dec.reg_data_op = RD_ALU;
               end
               FN_SUBU: begin
                  dec.seq         = SEQ_ALU;
                  dec.alu_op      = ALU_SUB;
                  dec.alu_b_op    = B_RT;
                  dec.reg_addr_op = RA_RD;
                  dec.reg_data_op = RD_ALU;
               end
               FN_SLL: begin
                  // The shifted operand is rt, so it goes on read port 1.
                  dec.seq         = SEQ_ALU;
                  dec.alu_op      = ALU_SLL;
                  dec.a1_op       = A1_RT;
                  dec.alu_b_op    = B_SHAMT;
                  dec.reg_addr_op = RA_RD;
                  dec.reg_data_op = RD_ALU;
               end
               FN_SLT: begin
                  // Comparison is formed from the subtract result in the datapath.
                  dec.seq         = SEQ_ALU;
                  dec.alu_op      = ALU_SUB;
                  dec.alu_b_op    = B_RT;
                  dec.reg_addr_op = RA_RD;
                  dec.reg_data_op = RD_SLT;
               end
               FN_JR: begin
                  dec.seq        = SEQ_BRANCH;
                  dec.next_pc_op = NPC_RS;
               end
               default: dec.seq = SEQ_ILLEGAL;
            endcase
         end
         OP_ORI: begin
            dec.seq         = SEQ_ALU;
            dec.alu_op      = ALU_OR;
            dec.alu_b_op    = B_ZIMM;
            dec.reg_addr_op = RA_RT;
            dec.reg_data_op = RD_ALU;
         end
         OP_LUI: begin
            dec.seq         = SEQ_ALU;
            dec.reg_addr_op = RA_RT;
            dec.reg_data_op = RD_LUI;
         end
         OP_LW: begin
            dec.seq         = SEQ_LOAD;
            dec.alu_op      = ALU_ADD;
            dec.alu_b_op    = B_SIMM;
            dec.reg_addr_op = RA_RT;
            dec.reg_data_op = RD_DM;
         end
         OP_LH: begin
            dec.seq         = SEQ_LOAD;
            dec.alu_op      = ALU_ADD;
            dec.alu_b_op    = B_SIMM;
            dec.reg_addr_op = RA_RT;
            dec.reg_data_op = RD_LH;
         end
         OP_SW: begin
            dec.seq      = SEQ_STORE;
            dec.alu_op   = ALU_ADD;
            dec.alu_b_op = B_SIMM;
         end
         OP_BEQ: begin
            dec.seq        = SEQ_BRANCH;
            dec.alu_op     = ALU_SUB;
            dec.alu_b_op   = B_RT;
            dec.next_pc_op = NPC_BEQ;
         end
         OP_JAL: begin
            dec.seq         = SEQ_JAL;
            dec.reg_addr_op = RA_R31;
            dec.reg_data_op = RD_PC4;
            dec.next_pc_op  = NPC_JUMP;
         end
         default: dec.seq = SEQ_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control unit.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   bus       master side of mc_controller_if (instr in, control strobes out)
//   state_o   out  current FSM state, for debug
//   retired   out  completed-instruction counter, wraps modulo 2^CNT_W
//   illegal   out  sticky flag, set on the first undecodable instruction
// The instruction register is loaded in FETCH; every control output is then
// a function of the state and the IR only. All outputs are forced low while
// reset is high so nothing fires during reset.
module mc_controller
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   mc_controller_if.master   bus,
   output logic [2:0]        state_o,
   output logic [CNT_W-1:0]  retired,
   output logic              illegal
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] ir;
   dec_t        dec;

   mc_decoder u_decoder (
      .ir  (ir),
      .dec (dec)
   );

   assign state_o = state;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_FETCH;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = ST_FETCH;
      case (state)
         ST_FETCH:  state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (dec.seq == SEQ_ILLEGAL)  state_nxt = ST_FETCH;
            else if (dec.seq == SEQ_JAL) state_nxt = ST_WB;
            else                         state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (dec.seq == SEQ_BRANCH)                                state_nxt = ST_FETCH;
            else if (dec.seq == SEQ_LOAD || dec.seq == SEQ_STORE)     state_nxt = ST_MEM;
            else                                                      state_nxt = ST_WB;
         end
         ST_MEM: begin
            if (dec.seq == SEQ_STORE) state_nxt = ST_FETCH;
            else                      state_nxt = ST_WB;
         end
         ST_WB:   state_nxt = ST_FETCH;
         default: state_nxt = ST_FETCH;
      endcase
   end

   // Output logic. ALU controls are driven identically in EXEC, MEM and WB
   // so the ALU result stays stable until it is written back.
   always_comb begin
      bus.ir_en       = 1'b0;
      bus.pc_en       = 1'b0;
      bus.next_pc_op  = NPC_PC4;
      bus.reg_write   = 1'b0;
      bus.a1_op       = A1_RS;
      bus.reg_addr_op = RA_RD;
      bus.reg_data_op = RD_ALU;
      bus.alu_op      = ALU_ADD;
      bus.alu_b_op    = B_RT;
      bus.mem_write   = 1'b0;
      if (!reset) begin
         if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            bus.alu_op   = dec.alu_op;
            bus.alu_b_op = dec.alu_b_op;
            bus.a1_op    = dec.a1_op;
         end
         case (state)
            ST_FETCH: bus.ir_en = 1'b1;
            ST_DECODE: begin
               // Illegal instructions finish here with a plain pc+4.
               if (dec.seq == SEQ_ILLEGAL) bus.pc_en = 1'b1;
            end
            ST_EXEC: begin
               if (dec.seq == SEQ_BRANCH) begin
                  bus.pc_en      = 1'b1;
                  bus.next_pc_op = dec.next_pc_op;
               end
            end
            ST_MEM: begin
               if (dec.seq == SEQ_STORE) begin
                  bus.mem_write = 1'b1;
                  bus.pc_en     = 1'b1;
               end
            end
            ST_WB: begin
               bus.reg_write   = 1'b1;
               bus.reg_addr_op = dec.reg_addr_op;
               bus.reg_data_op = dec.reg_data_op;
               bus.pc_en       = 1'b1;
               bus.next_pc_op  = dec.next_pc_op;
            end
            default: ;
         endcase
      end
   end

   // Instruction register: instr is only sampled on the FETCH strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          ir <= '0;
      else if (bus.ir_en) ir <= bus.instr;
   end

   // Retired counter: one count per pc_en, including illegal instructions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          retired <= '0;
      else if (bus.pc_en) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Sticky illegal flag, set when an undecodable IR is seen in DECODE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          illegal <= 1'b0;
      else if (state == ST_DECODE && dec.seq == SEQ_ILLEGAL) illegal <= 1'b1;
   end

endmodule
